// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, immediate/ALU codes, FSM states and decoded control bundle
package multicycle_ctrl_pkg;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef enum logic [2:0] {IMM_I, IMM_U, IMM_B, IMM_S, IMM_J} imm_t;
  localparam logic [4:0] SEL_ADD   = 5'd0;
  localparam logic [4:0] SEL_SUB   = 5'd1;
  localparam logic [4:0] SEL_SLL   = 5'd2;
  localparam logic [4:0] SEL_SLT   = 5'd4;
  localparam logic [4:0] SEL_SLTU  = 5'd6;
  localparam logic [4:0] SEL_XOR   = 5'd8;
  localparam logic [4:0] SEL_SRL   = 5'd10;
  localparam logic [4:0] SEL_SRA   = 5'd11;
  localparam logic [4:0] SEL_OR    = 5'd12;
  localparam logic [4:0] SEL_AND   = 5'd14;
  localparam logic [4:0] SEL_COPYB = 5'd15;
  localparam logic [4:0] SEL_MUL   = 5'd16;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MDU, S_WB, S_HALT, S_TRAP} state_t;
  typedef struct packed {
    imm_t       imm;
    logic       asrc;
    logic [1:0] bsrc;
    logic [4:0] sel;
    logic       word_op;
    logic       branch;
    logic       load;
    logic       store;
    logic       is_mem;
    logic       is_mdu;
    logic       writes_rd;
  } ctrl_t;
  function automatic logic [4:0] alu_sel(input logic [2:0] f3, input logic alt);
    return {1'b0, f3, alt};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational IR to control-field decoder
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int HAS_M = 0
) (
  input  logic [31:0] ir,
  output ctrl_t       ctrl,
  output logic        is_halt,
  output logic        is_illegal
);
  localparam bit RV64 = XLEN == 64;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       m_op;
  logic       f7_bad;
  // decode opcode/funct fields into the control bundle and legality
  always_comb begin
    f3 = ir[14:12];
    f7 = ir[31:25];
    m_op = f7 == 7'h01;
    f7_bad = !(f7 == 7'h00 || f7 == 7'h20 || (m_op && HAS_M != 0)) || (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
    is_halt = ir == 32'h0 || ir == EBREAK;
    is_illegal = 1'b0;
    ctrl = '0;
    case (ir[6:0])
      OPC_LUI: begin
        ctrl.imm = IMM_U; ctrl.bsrc = 2'b01; ctrl.sel = SEL_COPYB; ctrl.writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm = IMM_U; ctrl.asrc = 1'b1; ctrl.bsrc = 2'b01; ctrl.writes_rd = 1'b1;
      end
      OPC_JAL: begin
        ctrl.imm = IMM_J; ctrl.asrc = 1'b1; ctrl.bsrc = 2'b10; ctrl.branch = 1'b1; ctrl.writes_rd = 1'b1;
      end
      OPC_JALR: begin
        ctrl.asrc = 1'b1; ctrl.bsrc = 2'b10; ctrl.branch = 1'b1; ctrl.writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.imm = IMM_B; ctrl.branch = 1'b1;
        ctrl.sel = (f3[2] & f3[1]) ? SEL_SLTU : (f3[2] ^ f3[1]) ? SEL_SLT : SEL_SUB;
      end
      OPC_LOAD: begin
        ctrl.bsrc = 2'b01; ctrl.load = 1'b1; ctrl.is_mem = 1'b1; ctrl.writes_rd = 1'b1;
      end
      OPC_STORE: begin
        ctrl.imm = IMM_S; ctrl.bsrc = 2'b01; ctrl.store = 1'b1; ctrl.is_mem = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        ctrl.bsrc = 2'b01; ctrl.writes_rd = 1'b1;
        ctrl.sel = alu_sel(f3, f3 == 3'b101 && ir[30]);
        ctrl.word_op = RV64 && ir[3];
        is_illegal = ir[3] && !RV64;
      end
      OPC_OP, OPC_OP32: begin
        ctrl.writes_rd = 1'b1;
        ctrl.is_mdu = m_op;
        ctrl.sel = m_op ? (SEL_MUL | {2'b00, f3}) : alu_sel(f3, ir[30]);
        ctrl.word_op = RV64 && ir[3];
        is_illegal = f7_bad || (ir[3] && !RV64);
      end
      OPC_SYSTEM: ctrl = '0;
      default: is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle fetch/decode/exec/mem/mdu/wb control FSM
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int HAS_M       = 0,
  parameter int ALU_SEL_W   = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_valid,
  input  logic [31:0]          inst,
  output logic                 inst_ready,
  output logic                 lsu_req,
  output logic                 lsu_we,
  input  logic                 lsu_ack,
  output logic                 mdu_start,
  input  logic                 mdu_done,
  output logic [2:0]           op_imm,
  output logic                 op_alu_asrc,
  output logic [1:0]           op_alu_bsrc,
  output logic [ALU_SEL_W-1:0] op_alu_sel,
  output logic                 word_op,
  output logic                 branch,
  output logic                 load,
  output logic                 en_wmem,
  output logic                 en_wreg,
  output logic                 pc_update,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [2:0]           state
);
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  state_t        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  ctrl_t         ctrl_q, ctrl_d, dec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d, bus_err_q, bus_err_d, mdu_busy_q;
  logic          is_halt, is_illegal, timeout;
  multicycle_ctrl_decode #(.XLEN(XLEN), .HAS_M(HAS_M)) u_ctrl_decode (
    .ir(ir_q),
    .ctrl(dec),
    .is_halt(is_halt),
    .is_illegal(is_illegal)
  );
  assign timeout = MEM_TIMEOUT != 0 && cnt_q == LAST;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      ctrl_q <= '0;
      cnt_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      mdu_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      ctrl_q <= ctrl_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      mdu_busy_q <= state_q == S_MDU;
    end
  end
  // next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = inst_valid ? S_DECODE : S_FETCH;
      S_DECODE: state_d = is_halt ? S_HALT : is_illegal ? S_TRAP : S_EXEC;
      S_EXEC:   state_d = ctrl_q.is_mem ? S_MEM : (ctrl_q.is_mdu && HAS_M != 0) ? S_MDU : S_WB;
      S_MEM:    state_d = lsu_ack ? S_WB : timeout ? S_TRAP : S_MEM;
      S_MDU:    state_d = mdu_done ? S_WB : S_MDU;
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end
  // IR latch, decoded-field capture, MEM wait counter and sticky flags
  always_comb begin
    ir_d = (state_q == S_FETCH && inst_valid) ? inst : ir_q;
    ctrl_d = state_q == S_DECODE ? dec : ctrl_q;
    cnt_d = state_q == S_MEM ? cnt_q + 1'b1 : '0;
    illegal_d = illegal_q | (state_q == S_DECODE && !is_halt && is_illegal);
    bus_err_d = bus_err_q | (state_q == S_MEM && !lsu_ack && timeout);
  end
  // outputs decoded from state and registered fields
  always_comb begin
    inst_ready = state_q == S_FETCH && !rst;
    lsu_req = state_q == S_MEM;
    lsu_we = lsu_req && ctrl_q.store;
    en_wmem = lsu_req && lsu_we;
    mdu_start = state_q == S_MDU && !mdu_busy_q;
    pc_update = state_q == S_WB;
    en_wreg = pc_update && ctrl_q.writes_rd && ir_q[11:7] != 5'd0;
    halted = state_q == S_HALT || state_q == S_TRAP;
    op_imm = ctrl_q.imm;
    op_alu_asrc = ctrl_q.asrc;
    op_alu_bsrc = ctrl_q.bsrc;
    op_alu_sel = ALU_SEL_W'(ctrl_q.sel);
    word_op = ctrl_q.word_op;
    branch = ctrl_q.branch;
    load = ctrl_q.load;
    illegal = illegal_q;
    bus_err = bus_err_q;
    state = state_q;
  end
endmodule
